// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, EX hold states and opcodes.
// Also used by the decoder, so the opcode values must stay in step with it.
package pipe_pkg;

    localparam int CTRL_W        = 7;
    localparam int CTRL_NODEST   = 0;
    localparam int CTRL_REGDST   = 1;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_REGWRITE = 6;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic is_div(input logic valid, input logic [5:0] opcode);
        return valid && (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID instruction.
// Purely combinational; r0 never creates a dependency.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_alusrc,
    input  logic       id_memwrite,
    output logic       load_use
);

    logic id_reads_rt;
    logic rs_match;
    logic rt_match;

    // rt is a source for register-register ALU ops and for stores (store data).
    assign id_reads_rt = !id_alusrc || id_memwrite;
    assign rs_match    = (ex_rt == id_rs);
    assign rt_match    = (ex_rt == id_rt) && id_reads_rt;

    assign load_use = ex_valid && ex_memread && (ex_rt != 5'd0) && id_valid
                      && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion and, when DIV_STALL_EN is
// defined, a multi-cycle hold of EX while a DIV occupies it for DIV_CYCLES cycles.
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_rs_val,
    input  logic [31:0]       id_rt_val,
    input  logic [31:0]       id_imm,
    input  logic [31:0]       id_pc4,
    output logic              ex_valid,
    output logic [5:0]        ex_opcode,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_rs_val,
    output logic [31:0]       ex_rt_val,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_pc4,
    output logic              stall,
    output logic              div_busy,
    output logic              div_done
);

    if (DIV_CYCLES < 1) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be at least 1");
    end

    logic              ex_valid_reg;
    logic [5:0]        ex_opcode_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic [4:0]        ex_rs_reg;
    logic [4:0]        ex_rt_reg;
    logic [4:0]        ex_rd_reg;
    logic [31:0]       ex_rs_val_reg;
    logic [31:0]       ex_rt_val_reg;
    logic [31:0]       ex_imm_reg;
    logic [31:0]       ex_pc4_reg;

    logic load_use;
    logic ex_div;
    logic hold;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_valid_reg),
        .ex_memread  (ex_ctrl_reg[CTRL_MEMREAD]),
        .ex_rt       (ex_rt_reg),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_alusrc   (id_ctrl[CTRL_ALUSRC]),
        .id_memwrite (id_ctrl[CTRL_MEMWRITE]),
        .load_use    (load_use)
    );

    assign ex_div = is_div(ex_valid_reg, ex_opcode_reg);

`ifdef DIV_STALL_EN
    localparam int CNT_W      = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int CNT_INIT_I = (DIV_CYCLES > 1) ? (DIV_CYCLES - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_INIT_I[CNT_W-1:0];

    state_e           state_reg;
    state_e           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             div_enter;

    // The hold starts on the same edge that latches the DIV, so stall is already
    // high in the DIV's first EX cycle.
    assign div_enter = (DIV_CYCLES > 1) && !load_use && is_div(id_valid, id_opcode);
    assign hold      = (state_reg == DIV_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (div_enter) begin
                    state_next = DIV_WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
            DIV_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        div_busy = 1'b0;
        div_done = 1'b0;
        case (state_reg)
            RUN: begin
                stall    = load_use && !rst;
                div_done = ex_div;
            end
            DIV_WAIT: begin
                stall    = !rst;
                div_busy = 1'b1;
            end
            default: ;
        endcase
    end
`else
    assign hold     = 1'b0;
    assign stall    = load_use && !rst;
    assign div_busy = 1'b0;
    assign div_done = ex_div;
`endif

    // On a bubble only valid and ctrl are cleared; the data fields are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg  <= 1'b0;
            ex_opcode_reg <= '0;
            ex_ctrl_reg   <= '0;
            ex_rs_reg     <= '0;
            ex_rt_reg     <= '0;
            ex_rd_reg     <= '0;
            ex_rs_val_reg <= '0;
            ex_rt_val_reg <= '0;
            ex_imm_reg    <= '0;
            ex_pc4_reg    <= '0;
        end else if (!hold) begin
            if (load_use) begin
                ex_valid_reg <= 1'b0;
                ex_ctrl_reg  <= '0;
            end else begin
                ex_valid_reg  <= id_valid;
                ex_opcode_reg <= id_opcode;
                ex_ctrl_reg   <= id_ctrl;
                ex_rs_reg     <= id_rs;
                ex_rt_reg     <= id_rt;
                ex_rd_reg     <= id_rd;
                ex_rs_val_reg <= id_rs_val;
                ex_rt_val_reg <= id_rt_val;
                ex_imm_reg    <= id_imm;
                ex_pc4_reg    <= id_pc4;
            end
        end
    end

    assign ex_valid  = ex_valid_reg;
    assign ex_opcode = ex_opcode_reg;
    assign ex_ctrl   = ex_ctrl_reg;
    assign ex_rs     = ex_rs_reg;
    assign ex_rt     = ex_rt_reg;
    assign ex_rd     = ex_rd_reg;
    assign ex_rs_val = ex_rs_val_reg;
    assign ex_rt_val = ex_rt_val_reg;
    assign ex_imm    = ex_imm_reg;
    assign ex_pc4    = ex_pc4_reg;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: table of hazard vectors plus hand-written DIV and
// reset sequences; DIV expectations follow whether DIV_STALL_EN is defined for the build.
module tb_id_ex_pipe;
    import pipe_pkg::*;

    localparam int DIV_CYCLES = 4;
    localparam logic [6:0] CT_LW   = 7'b1110100;
    localparam logic [6:0] CT_ADD  = 7'b1000010;
    localparam logic [6:0] CT_ADDI = 7'b1000100;
    localparam logic [6:0] CT_SW   = 7'b0001101;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [6:0]  ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] pc4;
    } instr_t;

    typedef struct {
        instr_t ins;
        logic   exp_stall;
        logic   exp_bubble;
    } vec_t;

    typedef struct {
        instr_t ex;
        logic   bubble;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [6:0]  id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val, id_imm, id_pc4;
    logic        ex_valid;
    logic [5:0]  ex_opcode;
    logic [6:0]  ex_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc4;
    logic        stall, div_busy, div_done;

    instr_t ex_now;
    exp_t   sb[$];
    int     n_checks = 0;
    int     n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm), .id_pc4(id_pc4),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ctrl(ex_ctrl),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .stall(stall), .div_busy(div_busy), .div_done(div_done)
    );

    assign ex_now = {ex_valid, ex_opcode, ex_ctrl, ex_rs, ex_rt, ex_rd,
                     ex_rs_val, ex_rt_val, ex_imm, ex_pc4};

    function automatic instr_t mk(input logic v, input logic [5:0] op, input logic [6:0] ct,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        instr_t i;
        i.valid  = v;
        i.opcode = op;
        i.ctrl   = ct;
        i.rs     = rs;
        i.rt     = rt;
        i.rd     = rd;
        i.rs_val = $urandom;
        i.rt_val = $urandom;
        i.imm    = $urandom;
        i.pc4    = $urandom & 32'hFFFF_FFFC;
        return i;
    endfunction

    task automatic set_id(input instr_t i);
        id_valid  = i.valid;
        id_opcode = i.opcode;
        id_ctrl   = i.ctrl;
        id_rs     = i.rs;
        id_rt     = i.rt;
        id_rd     = i.rd;
        id_rs_val = i.rs_val;
        id_rt_val = i.rt_val;
        id_imm    = i.imm;
        id_pc4    = i.pc4;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_ex(input string name);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (e.bubble) begin
                if ({ex_valid, ex_ctrl} !== 8'h00) begin
                    n_err++;
                    $display("FAIL %s: got valid=%b ctrl=%b want bubble", name, ex_valid, ex_ctrl);
                end
            end else if (ex_now !== e.ex) begin
                n_err++;
                $display("FAIL %s: got ex=%h want %h", name, ex_now, e.ex);
            end
        end
    endtask

    // Called at posedge+1: drive ID, check combinational outputs, then check EX after the edge.
    task automatic cycle(input string name, input instr_t ins, input logic e_stall,
                         input logic e_busy, input logic e_done, input instr_t e_ex,
                         input logic e_bubble);
        set_id(ins);
        #1;
        check_bit({name, " stall"}, stall, e_stall);
        check_bit({name, " div_busy"}, div_busy, e_busy);
        check_bit({name, " div_done"}, div_done, e_done);
        sb.push_back('{ex: e_ex, bubble: e_bubble});
        @(posedge clk);
        #1;
        check_ex({name, " ex"});
        $display("%s: stall=%b busy=%b done=%b -> ex_valid=%b ex_op=%h ex_ctrl=%b",
                 name, stall, div_busy, div_done, ex_valid, ex_opcode, ex_ctrl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t   vecs[15];
        instr_t add1, sw1, add2, r, div, x, divh, lw5, nop;
        bit     use_hold;
`ifdef DIV_STALL_EN
        use_hold = 1'b1;
`else
        use_hold = 1'b0;
`endif
        add1 = mk(1, OP_RTYPE, CT_ADD, 5, 2, 7);
        sw1  = mk(1, OP_SW, CT_SW, 3, 5, 0);
        add2 = mk(1, OP_RTYPE, CT_ADD, 2, 8, 9);
        vecs[0]  = '{mk(1, OP_LW, CT_LW, 1, 5, 0), 1'b0, 1'b0};
        vecs[1]  = '{add1, 1'b1, 1'b1};
        vecs[2]  = '{add1, 1'b0, 1'b0};
        vecs[3]  = '{mk(1, OP_LW, CT_LW, 1, 0, 0), 1'b0, 1'b0};
        vecs[4]  = '{mk(1, OP_RTYPE, CT_ADD, 0, 0, 4), 1'b0, 1'b0};
        vecs[5]  = '{mk(1, OP_LW, CT_LW, 1, 5, 0), 1'b0, 1'b0};
        vecs[6]  = '{mk(1, OP_ADDI, CT_ADDI, 3, 5, 0), 1'b0, 1'b0};
        vecs[7]  = '{mk(1, OP_LW, CT_LW, 1, 5, 0), 1'b0, 1'b0};
        vecs[8]  = '{sw1, 1'b1, 1'b1};
        vecs[9]  = '{sw1, 1'b0, 1'b0};
        vecs[10] = '{mk(1, OP_LW, CT_LW, 1, 6, 0), 1'b0, 1'b0};
        vecs[11] = '{mk(0, OP_RTYPE, CT_ADD, 1, 6, 2), 1'b0, 1'b0};
        vecs[12] = '{mk(1, OP_LW, CT_LW, 1, 8, 0), 1'b0, 1'b0};
        vecs[13] = '{add2, 1'b1, 1'b1};
        vecs[14] = '{add2, 1'b0, 1'b0};

        // Reset with a live instruction on the ID inputs.
        rst = 1'b1;
        set_id(mk(1, OP_LW, CT_LW, 7, 7, 7));
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ex_now !== '0) begin
            n_err++;
            $display("FAIL reset ex: got %h want 0", ex_now);
        end
        check_bit("reset stall", stall, 1'b0);
        check_bit("reset div_busy", div_busy, 1'b0);
        check_bit("reset div_done", div_done, 1'b0);
        $display("reset: ex_valid=%b stall=%b", ex_valid, stall);
        rst = 1'b0;
        r = mk(1, OP_ADDI, CT_ADDI, 1, 2, 0);
        r.imm = 32'h0000_1234;
        cycle("post_reset", r, 1'b0, 1'b0, 1'b0, r, 1'b0);

        for (int i = 0; i < 15; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].ins, vecs[i].exp_stall, 1'b0, 1'b0,
                  vecs[i].ins, vecs[i].exp_bubble);
        end

        // DIV hold: next instruction waits in ID until the DIV's final EX cycle.
        div = mk(1, OP_DIV, CT_ADD, 2, 3, 0);
        x   = mk(1, OP_RTYPE, CT_ADD, 4, 11, 6);
        nop = mk(0, OP_RTYPE, 7'b0, 0, 0, 0);
        cycle("div_in", div, 1'b0, 1'b0, 1'b0, div, 1'b0);
        if (use_hold) begin
            for (int k = 0; k < DIV_CYCLES - 1; k++)
                cycle($sformatf("div_hold%0d", k), x, 1'b1, 1'b1, 1'b0, div, 1'b0);
        end
        cycle("div_last", x, 1'b0, 1'b0, 1'b1, x, 1'b0);
        cycle("after_div", nop, 1'b0, 1'b0, 1'b0, nop, 1'b0);

        // DIV that depends on a load: bubble first, then the hold.
        lw5  = mk(1, OP_LW, CT_LW, 1, 5, 0);
        divh = mk(1, OP_DIV, CT_ADD, 5, 2, 3);
        cycle("lw_before_div", lw5, 1'b0, 1'b0, 1'b0, lw5, 1'b0);
        cycle("div_hazard", divh, 1'b1, 1'b0, 1'b0, divh, 1'b1);
        cycle("div_after_bubble", divh, 1'b0, 1'b0, 1'b0, divh, 1'b0);
        if (use_hold) begin
            for (int k = 0; k < DIV_CYCLES - 1; k++)
                cycle($sformatf("dh_hold%0d", k), x, 1'b1, 1'b1, 1'b0, divh, 1'b0);
        end
        cycle("dh_last", x, 1'b0, 1'b0, 1'b1, x, 1'b0);

        // Reset in the second EX cycle of a DIV.
        cycle("div_in2", div, 1'b0, 1'b0, 1'b0, div, 1'b0);
        if (use_hold)
            cycle("div2_n", x, 1'b1, 1'b1, 1'b0, div, 1'b0);
        else
            cycle("div2_n", x, 1'b0, 1'b0, 1'b1, x, 1'b0);
        rst = 1'b1;
        set_id(x);
        #1;
        check_bit("mid_rst stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_bit("mid_rst div_busy", div_busy, 1'b0);
        check_bit("mid_rst ex_valid", ex_valid, 1'b0);
        check_bit("mid_rst div_done", div_done, 1'b0);
        check_bit("mid_rst stall_after", stall, 1'b0);
        $display("mid_rst: busy=%b ex_valid=%b done=%b", div_busy, ex_valid, div_done);
        @(posedge clk);
        #1;
        check_bit("post_rst div_done", div_done, 1'b0);
        cycle("post_rst_run", x, 1'b0, 1'b0, 1'b0, x, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
